// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Purpose  : Shared encodings for the RV32I multi-cycle control path.
// Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_OPIMM   = 4'd8,
        CLS_OP      = 4'd9
    } inst_cls_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_IU = 3'b001;
    localparam logic [2:0] IMM_SH = 3'b010;
    localparam logic [2:0] IMM_S  = 3'b011;
    localparam logic [2:0] IMM_B  = 3'b100;
    localparam logic [2:0] IMM_U  = 3'b101;
    localparam logic [2:0] IMM_J  = 3'b110;

    // alu_op = {inst[30], funct3} for register/immediate arithmetic
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_REL  = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rv_mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_decode
// Purpose  : Combinational instruction classifier; yields imm_sel/alu_op.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mc_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output inst_cls_t   cls,
    output logic [2:0]  imm_sel,
    output logic [3:0]  alu_op,
    output logic        legal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_unused;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];
    assign w_unused = ^{inst[31], inst[29:15], inst[11:7]};

    // Every supported opcode ends in 2'b11, so matching the full opcode
    // also rejects compressed encodings.
    always_comb begin
        cls     = CLS_ILLEGAL;
        imm_sel = IMM_I;
        alu_op  = ALU_ADD;
        case (w_opcode)
            OPC_LUI: begin
                cls     = CLS_LUI;
                imm_sel = IMM_U;
            end
            OPC_AUIPC: begin
                cls     = CLS_AUIPC;
                imm_sel = IMM_U;
            end
            OPC_JAL: begin
                cls     = CLS_JAL;
                imm_sel = IMM_J;
            end
            OPC_JALR: begin
                cls     = CLS_JALR;
            end
            OPC_BRANCH: begin
                cls     = CLS_BRANCH;
                imm_sel = IMM_B;
                alu_op  = ALU_SUB;
            end
            OPC_LOAD: begin
                cls     = CLS_LOAD;
            end
            OPC_STORE: begin
                cls     = CLS_STORE;
                imm_sel = IMM_S;
            end
            OPC_OPIMM: begin
                cls     = CLS_OPIMM;
                imm_sel = ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) ? IMM_SH : IMM_I;
                alu_op  = {(w_funct3 == 3'b101) & inst[30], w_funct3};
            end
            OPC_OP: begin
                cls     = CLS_OP;
                alu_op  = {inst[30], w_funct3};
            end
            default: begin
                cls     = CLS_ILLEGAL;
            end
        endcase
    end

    assign legal = (cls != CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_ctrl
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for RV32I.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mc_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [3:0]  alu_op,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state_o
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_illegal;
    logic       w_set_illegal;

    inst_cls_t  w_cls;
    logic [2:0] w_dec_imm_sel;
    logic [3:0] w_dec_alu_op;
    logic       w_legal;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_mem_addr_sel;
    logic       w_ir_we;
    logic       w_pc_we;
    logic [1:0] w_pc_sel;
    logic [2:0] w_imm_sel;
    logic       w_alu_src_a;
    logic       w_alu_src_b;
    logic [3:0] w_alu_op;
    logic       w_reg_we;
    logic [1:0] w_wb_sel;

    rv_mc_decode u_decode (
        .inst    (inst),
        .cls     (w_cls),
        .imm_sel (w_dec_imm_sel),
        .alu_op  (w_dec_alu_op),
        .legal   (w_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_set_illegal  = 1'b0;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_sel       = PC_SEL_PC4;
        w_imm_sel      = IMM_I;
        w_alu_src_a    = 1'b0;
        w_alu_src_b    = 1'b0;
        w_alu_op       = ALU_ADD;
        w_reg_we       = 1'b0;
        w_wb_sel       = WB_ALU;

        // Datapath selects follow the IR for the whole life of the instruction
        // so the ALU result register stays stable through MEM and WB.
        if (r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            w_imm_sel   = w_dec_imm_sel;
            w_alu_op    = w_dec_alu_op;
            w_alu_src_a = (w_cls == CLS_AUIPC);
            w_alu_src_b = (w_cls != CLS_OP) && (w_cls != CLS_BRANCH);
        end

        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we     = 1'b1;
                    w_pc_we     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_legal) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    w_state_nxt   = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (w_cls)
                    CLS_LUI: begin
                        w_reg_we    = 1'b1;
                        w_wb_sel    = WB_IMM;
                        w_state_nxt = ST_FETCH;
                    end
                    CLS_JAL: begin
                        w_reg_we    = 1'b1;
                        w_wb_sel    = WB_PC4;
                        w_pc_we     = 1'b1;
                        w_pc_sel    = PC_SEL_REL;
                        w_state_nxt = ST_FETCH;
                    end
                    CLS_JALR: begin
                        w_reg_we    = 1'b1;
                        w_wb_sel    = WB_PC4;
                        w_pc_we     = 1'b1;
                        w_pc_sel    = PC_SEL_JALR;
                        w_state_nxt = ST_FETCH;
                    end
                    CLS_BRANCH: begin
                        w_pc_we     = br_taken;
                        w_pc_sel    = PC_SEL_REL;
                        w_state_nxt = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        w_state_nxt = ST_MEM;
                    end
                    default: begin
                        w_state_nxt = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (w_cls == CLS_STORE);
                if (mem_ready) begin
                    w_state_nxt = (w_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                w_reg_we    = 1'b1;
                w_wb_sel    = (w_cls == CLS_LOAD) ? WB_MEM : WB_ALU;
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // While rst_n is low every output shows its reset value, which also
    // kills any access in flight and gives rst_n priority over mem_ready.
    assign mem_req      = rst_n & w_mem_req;
    assign mem_we       = rst_n & w_mem_we;
    assign mem_addr_sel = rst_n & w_mem_addr_sel;
    assign ir_we        = rst_n & w_ir_we;
    assign pc_we        = rst_n & w_pc_we;
    assign pc_sel       = rst_n ? w_pc_sel  : PC_SEL_PC4;
    assign imm_sel      = rst_n ? w_imm_sel : IMM_I;
    assign alu_src_a    = rst_n & w_alu_src_a;
    assign alu_src_b    = rst_n & w_alu_src_b;
    assign alu_op       = rst_n ? w_alu_op  : ALU_ADD;
    assign reg_we       = rst_n & w_reg_we;
    assign wb_sel       = rst_n ? w_wb_sel  : WB_ALU;
    assign illegal      = rst_n & r_illegal;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mc_ctrl
// Purpose  : Self-checking bench for rv_mc_ctrl against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mc_ctrl;

    localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4;
    localparam int K_LOAD = 5, K_STORE = 6, K_OPIMM = 7, K_OP = 8, K_BAD = 9;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic        alu_src_a, alu_src_b;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state_o;
    logic [19:0] all_out;

    int n_cmp = 0;
    int n_err = 0;

    assign all_out = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, imm_sel,
                      alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rv_mc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .br_taken     (br_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .state_o      (state_o)
    );

    // ---------------- reference model (RV32I base opcode map) ----------------
    function automatic int kind_of(input logic [31:0] i);
        if (i[1:0] != 2'b11) return K_BAD;
        case (i[6:2])
            5'b01101: return K_LUI;
            5'b00101: return K_AUIPC;
            5'b11011: return K_JAL;
            5'b11001: return K_JALR;
            5'b11000: return K_BR;
            5'b00000: return K_LOAD;
            5'b01000: return K_STORE;
            5'b00100: return K_OPIMM;
            5'b01100: return K_OP;
            default:  return K_BAD;
        endcase
    endfunction

    function automatic logic [2:0] ref_imm(input logic [31:0] i);
        int k = kind_of(i);
        if (k == K_OPIMM) return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 3'd2 : 3'd0;
        if (k == K_STORE) return 3'd3;
        if (k == K_BR) return 3'd4;
        if (k == K_LUI || k == K_AUIPC) return 3'd5;
        if (k == K_JAL) return 3'd6;
        return 3'd0;
    endfunction

    function automatic logic [3:0] ref_aop(input logic [31:0] i);
        int k = kind_of(i);
        if (k == K_OP) return {i[30], i[14:12]};
        if (k == K_OPIMM) return {(i[14:12] == 3'd5) ? i[30] : 1'b0, i[14:12]};
        if (k == K_BR) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] make_inst(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_LUI:   r[6:0] = 7'h37;
            K_AUIPC: r[6:0] = 7'h17;
            K_JAL:   r[6:0] = 7'h6F;
            K_JALR:  r[6:0] = 7'h67;
            K_BR:    r[6:0] = 7'h63;
            K_LOAD:  r[6:0] = 7'h03;
            K_STORE: r[6:0] = 7'h23;
            K_OPIMM: r[6:0] = 7'h13;
            K_OP:    r[6:0] = 7'h33;
            default: while (kind_of(r) != K_BAD) r = $urandom;
        endcase
        return r;
    endfunction

    // Runs one legal instruction from FETCH to its return to FETCH.
    // Called and returns at posedge+1.
    task automatic run_instr(input logic [31:0] i, input int fw, input int mw,
                             input logic taken, input string tag);
        int k, n_ir, n_pc, n_rw, n_mw, e_pc, e_rw, e_mw;
        logic [2:0] exp_st[$];
        logic       exp_rdy[$];
        logic       is_ls, has_wb, is_jump, wr_rd, is_st;
        logic [1:0] e_wb, e_ps;
        k       = kind_of(i);
        is_ls   = (k == K_LOAD) || (k == K_STORE);
        is_st   = (k == K_STORE);
        has_wb  = (k == K_LOAD) || (k == K_OP) || (k == K_OPIMM) || (k == K_AUIPC);
        is_jump = (k == K_JAL) || (k == K_JALR) || ((k == K_BR) && taken);
        wr_rd   = (k == K_LUI) || (k == K_JAL) || (k == K_JALR);
        e_wb    = (k == K_LUI) ? 2'b11 : 2'b10;
        e_ps    = (k == K_JALR) ? 2'b10 : 2'b01;
        for (int c = 0; c <= fw; c++) begin exp_st.push_back(3'd0); exp_rdy.push_back(c == fw); end
        exp_st.push_back(3'd1); exp_rdy.push_back(1'b0);
        exp_st.push_back(3'd2); exp_rdy.push_back(1'b0);
        if (is_ls)
            for (int c = 0; c <= mw; c++) begin exp_st.push_back(3'd3); exp_rdy.push_back(c == mw); end
        if (has_wb) begin exp_st.push_back(3'd4); exp_rdy.push_back(1'b0); end
        n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0;
        for (int c = 0; c < exp_st.size(); c++) begin
            inst      = (exp_st[c] == 3'd0) ? $urandom : i;
            mem_ready = (exp_st[c] == 3'd0 || exp_st[c] == 3'd3) ? exp_rdy[c] : 1'($urandom);
            br_taken  = (exp_st[c] == 3'd2) ? taken : 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (state_o !== exp_st[c] || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL %s state cyc%0d: got state %0d illegal %b, want state %0d illegal 0",
                         tag, c, state_o, illegal, exp_st[c]);
            end
            n_ir += int'(ir_we); n_pc += int'(pc_we); n_rw += int'(reg_we); n_mw += int'(mem_we);
            case (exp_st[c])
                3'd0: begin
                    n_cmp++;
                    if ({mem_req, mem_addr_sel, mem_we, ir_we, pc_we, pc_sel} !==
                        {3'b100, exp_rdy[c], exp_rdy[c], 2'b00}) begin
                        n_err++;
                        $display("FAIL %s fetch cyc%0d: got req/asel/we/ir/pc/psel %b%b%b%b%b%b want 100%b%b00",
                                 tag, c, mem_req, mem_addr_sel, mem_we, ir_we, pc_we, pc_sel,
                                 exp_rdy[c], exp_rdy[c]);
                    end
                end
                3'd1: begin
                    n_cmp++;
                    if ({mem_req, mem_we, ir_we, pc_we, reg_we} !== 5'b0) begin
                        n_err++;
                        $display("FAIL %s decode enables: got %b want 00000", tag,
                                 {mem_req, mem_we, ir_we, pc_we, reg_we});
                    end
                end
                3'd2: begin
                    n_cmp++;
                    if (imm_sel !== ref_imm(i)) begin
                        n_err++;
                        $display("FAIL %s imm_sel: got %b want %b", tag, imm_sel, ref_imm(i));
                    end
                    if (k != K_LUI && k != K_JAL) begin
                        n_cmp++;
                        if (alu_op !== ref_aop(i)) begin
                            n_err++;
                            $display("FAIL %s alu_op: got %b want %b", tag, alu_op, ref_aop(i));
                        end
                    end
                    n_cmp++;
                    if ({reg_we, pc_we, mem_req, ir_we} !== {wr_rd, is_jump, 2'b00}) begin
                        n_err++;
                        $display("FAIL %s exec reg_we/pc_we/req/ir: got %b%b%b%b want %b%b00",
                                 tag, reg_we, pc_we, mem_req, ir_we, wr_rd, is_jump);
                    end
                    if (wr_rd) begin
                        n_cmp++;
                        if (wb_sel !== e_wb) begin
                            n_err++;
                            $display("FAIL %s exec wb_sel: got %b want %b", tag, wb_sel, e_wb);
                        end
                    end
                    if (k == K_JAL || k == K_JALR || k == K_BR) begin
                        n_cmp++;
                        if (pc_sel !== e_ps) begin
                            n_err++;
                            $display("FAIL %s exec pc_sel: got %b want %b", tag, pc_sel, e_ps);
                        end
                    end
                    if (k == K_OP || k == K_OPIMM || k == K_AUIPC) begin
                        n_cmp++;
                        if ({alu_src_a, alu_src_b} !== {k == K_AUIPC, k != K_OP}) begin
                            n_err++;
                            $display("FAIL %s alu_src a/b: got %b%b want %b%b", tag,
                                     alu_src_a, alu_src_b, k == K_AUIPC, k != K_OP);
                        end
                    end
                end
                3'd3: begin
                    n_cmp++;
                    if ({mem_req, mem_addr_sel, mem_we, ir_we, pc_we, reg_we} !== {2'b11, is_st, 3'b000}) begin
                        n_err++;
                        $display("FAIL %s mem cyc%0d: got req/asel/we/ir/pc/rw %b want 11%b000", tag, c,
                                 {mem_req, mem_addr_sel, mem_we, ir_we, pc_we, reg_we}, is_st);
                    end
                end
                default: begin
                    n_cmp++;
                    if ({reg_we, wb_sel, mem_req, pc_we} !== {1'b1, (k == K_LOAD) ? 2'b01 : 2'b00, 2'b00}) begin
                        n_err++;
                        $display("FAIL %s wb: got rw/wb_sel/req/pc %b%b%b%b want 1%b00", tag,
                                 reg_we, wb_sel, mem_req, pc_we, (k == K_LOAD) ? 2'b01 : 2'b00);
                    end
                end
            endcase
            @(posedge clk); #1;
        end
        e_pc = is_jump ? 2 : 1;
        e_rw = (k == K_STORE || k == K_BR) ? 0 : 1;
        e_mw = is_st ? mw + 1 : 0;
        n_cmp++;
        if (n_ir != 1 || n_pc != e_pc || n_rw != e_rw || n_mw != e_mw) begin
            n_err++;
            $display("FAIL %s pulse counts ir/pc/reg/memwe: got %0d/%0d/%0d/%0d want 1/%0d/%0d/%0d",
                     tag, n_ir, n_pc, n_rw, n_mw, e_pc, e_rw, e_mw);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; inst = $urandom; mem_ready = 1'b1; br_taken = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (all_out !== 20'd0 || state_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset: got outputs %h state %0d, want 00000 state 0", all_out, state_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        run_instr(32'h00500093, 0, 0, 1'b0, "addi");
    endtask

    task automatic test_load_wait();
        run_instr(32'h0040A103, 0, 2, 1'b0, "lw_wait2");
    endtask

    task automatic test_store();
        run_instr(32'h0020A423, 0, 0, 1'b0, "sw");
    endtask

    task automatic test_branch();
        run_instr(32'h00000463, 0, 0, 1'b1, "beq_taken");
        run_instr(32'h00000463, 0, 0, 1'b0, "beq_not");
    endtask

    task automatic test_jal();
        run_instr(32'h010000EF, 1, 0, 1'b0, "jal");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 8);
            run_instr(make_inst(k), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_reset_mid_fetch();
        inst = $urandom; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state_o !== 3'd0 || mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid pre: got state %0d req %b want 0 1", state_o, mem_req);
        end
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ir_we, pc_we, mem_req} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid ready: got ir/pc/req %b%b%b want 000", ir_we, pc_we, mem_req);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (all_out !== 20'd0 || state_o !== 3'd0) begin
            n_err++;
            $display("FAIL rst_mid after: got outputs %h state %0d want 00000 state 0", all_out, state_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(32'h00500093, 0, 0, 1'b0, "addi_after_rst");
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'hFFFFFFFF;
        bad[1] = make_inst(K_BAD);
        for (int b = 0; b < 2; b++) begin
            inst = $urandom; mem_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (state_o !== 3'd0) begin
                n_err++;
                $display("FAIL illegal%0d fetch: got state %0d want 0", b, state_o);
            end
            @(posedge clk); #1;
            inst = bad[b]; mem_ready = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (state_o !== 3'd1 || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL illegal%0d decode: got state %0d illegal %b want 1 0", b, state_o, illegal);
            end
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                mem_ready = 1'b1; br_taken = 1'($urandom);
                @(negedge clk);
                n_cmp++;
                if (state_o !== 3'd5 || illegal !== 1'b1 ||
                    {mem_req, mem_we, ir_we, pc_we, reg_we} !== 5'b0) begin
                    n_err++;
                    $display("FAIL illegal%0d halt cyc%0d: got state %0d illegal %b en %b want 5 1 00000",
                             b, c, state_o, illegal, {mem_req, mem_we, ir_we, pc_we, reg_we});
                end
            end
            @(posedge clk); #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1; mem_ready = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (state_o !== 3'd0 || illegal !== 1'b0 || mem_req !== 1'b1) begin
                n_err++;
                $display("FAIL illegal%0d recover: got state %0d illegal %b req %b want 0 0 1",
                         b, state_o, illegal, mem_req);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; inst = '0; br_taken = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_load_wait();
        test_store();
        test_branch();
        test_jal();
        test_back_to_back();
        test_reset_mid_fetch();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
